// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths, RV32 opcodes, fetch FSM states and immediate extractors
package ifetch_pkg;
   localparam int REG_DAT_W = 32;
   localparam int INS_DAT_W = 32;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DROP} state_t;
   function automatic logic [REG_DAT_W-1:0] imm_j(input logic [INS_DAT_W-1:0] i);
      return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
   endfunction
   function automatic logic [REG_DAT_W-1:0] imm_b(input logic [INS_DAT_W-1:0] i);
      return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
   endfunction
endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: icache request/response, issue output and ROB redirect/BHT update signals
interface ifetch_if;
   import ifetch_pkg::*;
   logic                 ic_en;
   logic [REG_DAT_W-1:0] ic_addr;
   logic                 ic_valid;
   logic [INS_DAT_W-1:0] ic_ins;
   logic                 is_en;
   logic [INS_DAT_W-1:0] is_ins;
   logic                 is_bj;
   logic [REG_DAT_W-1:0] is_pc;
   logic [REG_DAT_W-1:0] is_pjt;
   logic                 rob_flush;
   logic [REG_DAT_W-1:0] rob_pc;
   logic                 rob_bht_en;
   logic [REG_DAT_W-1:0] rob_bht_pc;
   logic                 rob_bht_taken;
   modport master (
      output ic_en, ic_addr, is_en, is_ins, is_bj, is_pc, is_pjt,
      input  ic_valid, ic_ins, rob_flush, rob_pc, rob_bht_en, rob_bht_pc, rob_bht_taken
   );
   modport slave (
      input  ic_en, ic_addr, is_en, is_ins, is_bj, is_pc, is_pjt,
      output ic_valid, ic_ins, rob_flush, rob_pc, rob_bht_en, rob_bht_pc, rob_bht_taken
   );
endinterface

// File: rtl/ifetch_bht.sv
// ifetch_bht: 2^IDX_W two-bit saturating direction counters, async read, one update port
module ifetch_bht #(
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             taken,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken
);
   logic [1:0] cnt [1 << IDX_W];
   assign taken = cnt[rd_idx][1];
   // counters start weakly not-taken and saturate at 0 and 3
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < (1 << IDX_W); i++) cnt[i] <= 2'b01;
      end else if (upd_en) begin
         cnt[upd_idx] <= upd_taken ? (cnt[upd_idx] == 2'd3 ? 2'd3 : cnt[upd_idx] + 2'd1)
                                   : (cnt[upd_idx] == 2'd0 ? 2'd0 : cnt[upd_idx] - 2'd1);
      end
   end
endmodule

// File: rtl/ifetch.sv
// ifetch: fetch PC, single-outstanding icache request, predecode and next-PC prediction (IFETCH_BHT_EN: BHT, else static backward-taken)
module ifetch
   import ifetch_pkg::*;
#(
   parameter logic [REG_DAT_W-1:0] RESET_PC  = 32'h0,
   parameter int                   BHT_IDX_W = 6
) (
   input logic      clk,
   input logic      rst,
   input logic      en,
   ifetch_if.master bus
);
   state_t               state;
   logic [REG_DAT_W-1:0] pc;
   logic [REG_DAT_W-1:0] pjt;
   logic [6:0]           opc;
   logic                 bj;
   logic                 taken;
`ifdef IFETCH_BHT_EN
   ifetch_bht #(.IDX_W(BHT_IDX_W)) u_bht (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (pc[BHT_IDX_W+1:2]),
      .taken     (taken),
      .upd_en    (bus.rob_bht_en),
      .upd_idx   (bus.rob_bht_pc[BHT_IDX_W+1:2]),
      .upd_taken (bus.rob_bht_taken)
   );
`else
   assign taken = bus.ic_ins[31];
`endif
   assign bus.ic_en   = en && !bus.rob_flush && (state == S_IDLE || state == S_HOLD);
   assign bus.ic_addr = {pc[REG_DAT_W-1:2], 2'b00};
   // predecode the returning word against the PC it was fetched from
   always_comb begin
      opc = bus.ic_ins[6:0];
      bj  = opc == OP_JAL || opc == OP_JALR || opc == OP_BRANCH;
      pjt = pc + (opc == OP_JAL ? imm_j(bus.ic_ins)
                : (opc == OP_BRANCH && taken) ? imm_b(bus.ic_ins) : 32'd4);
   end
   // fetch FSM: flush wins over everything, response capture ignores the stall
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         pc         <= RESET_PC;
         bus.is_en  <= 1'b0;
         bus.is_ins <= '0;
         bus.is_bj  <= 1'b0;
         bus.is_pc  <= '0;
         bus.is_pjt <= '0;
      end else if (bus.rob_flush) begin
         pc        <= bus.rob_pc;
         bus.is_en <= 1'b0;
         state     <= (state == S_DROP || (state == S_WAIT && !bus.ic_valid)) ? S_DROP : S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (en) state <= S_WAIT;
            S_WAIT: if (bus.ic_valid) begin
               bus.is_en  <= 1'b1;
               bus.is_ins <= bus.ic_ins;
               bus.is_bj  <= bj;
               bus.is_pc  <= pc;
               bus.is_pjt <= pjt;
               pc         <= pjt;
               state      <= S_HOLD;
            end
            S_HOLD: if (en) begin
               bus.is_en <= 1'b0;
               state     <= S_WAIT;
            end
            S_DROP: if (bus.ic_valid) state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed and randomized checks of ifetch against a behavioural fetch/predict model
module tb_ifetch;
   logic clk = 1'b0;
   logic rst;
   logic en;
   ifetch_if bus();
   ifetch dut (.clk(clk), .rst(rst), .en(en), .bus(bus));
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [31:0] m_pc;
   logic [1:0]  m_bht [64];

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] m_pjt(input logic [31:0] pc, input logic [31:0] ins, input logic tk);
      int off;
      off = 4;
      if (ins[6:0] == 7'h6F)
         off = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096 - int'(ins[31]) * 1048576;
      else if (ins[6:0] == 7'h63 && tk)
         off = int'(ins[11:8]) * 2 + int'(ins[30:25]) * 32 + int'(ins[7]) * 2048 - int'(ins[31]) * 4096;
      return pc + off;
   endfunction

   task automatic wait_req(output logic ok);
      int n;
      n = 0;
      while (bus.ic_en !== 1'b1 && n < 10) begin
         @(negedge clk); #1;
         n++;
      end
      checks++;
      ok = (bus.ic_en === 1'b1);
      if (!ok) begin
         failures++;
         $display("FAIL req_timeout ic_en=%b want 1", bus.ic_en);
         return;
      end
      checks++;
      if (bus.ic_addr !== {m_pc[31:2], 2'b00}) begin
         failures++;
         $display("FAIL req_addr got=%h want=%h", bus.ic_addr, {m_pc[31:2], 2'b00});
      end
   endtask

   task automatic respond(input logic [31:0] ins, input int lat);
      logic tk, exp_bj;
      logic [31:0] exp_pjt;
      for (int k = 1; k < lat; k++) begin
         @(negedge clk); #1;
         checks++;
         if (bus.ic_en !== 1'b0 || bus.is_en !== 1'b0) begin
            failures++;
            $display("FAIL wait_quiet ic_en=%b is_en=%b want 0 0", bus.ic_en, bus.is_en);
         end
      end
      @(negedge clk);
      bus.ic_valid = 1'b1;
      bus.ic_ins = ins;
`ifdef IFETCH_BHT_EN
      tk = m_bht[m_pc[7:2]] >= 2'd2;
`else
      tk = ins[31];
`endif
      exp_bj = ins[6:0] == 7'h6F || ins[6:0] == 7'h67 || ins[6:0] == 7'h63;
      exp_pjt = m_pjt(m_pc, ins, tk);
      @(negedge clk);
      bus.ic_valid = 1'b0;
      #1;
      checks++;
      if ({bus.is_en, bus.is_ins, bus.is_bj, bus.is_pc, bus.is_pjt, bus.ic_en, bus.ic_addr} !==
          {1'b1, ins, exp_bj, m_pc, exp_pjt, 1'b1, exp_pjt[31:2], 2'b00}) begin
         failures++;
         $display("FAIL issue ins=%h got en=%b ins=%h bj=%b pc=%h pjt=%h ic_en=%b addr=%h want en=1 bj=%b pc=%h pjt=%h ic_en=1",
                  ins, bus.is_en, bus.is_ins, bus.is_bj, bus.is_pc, bus.is_pjt, bus.ic_en, bus.ic_addr,
                  exp_bj, m_pc, exp_pjt);
      end
      m_pc = exp_pjt;
   endtask

   task automatic fetch_one(input logic [31:0] ins, input int lat);
      logic ok;
      wait_req(ok);
      if (ok) respond(ins, lat);
   endtask

   task automatic do_flush(input logic [31:0] pc);
      bus.rob_flush = 1'b1;
      bus.rob_pc = pc;
      #1;
      checks++;
      if (bus.ic_en !== 1'b0) begin
         failures++;
         $display("FAIL flush_ic_en got=%b want 0", bus.ic_en);
      end
      @(negedge clk);
      bus.rob_flush = 1'b0;
      #1;
      checks++;
      if (bus.is_en !== 1'b0) begin
         failures++;
         $display("FAIL flush_is_en got=%b want 0", bus.is_en);
      end
      m_pc = pc;
   endtask

   task automatic bht_update(input logic [31:0] pc, input logic tk);
      en = 1'b0;
      bus.rob_bht_en = 1'b1;
      bus.rob_bht_pc = pc;
      bus.rob_bht_taken = tk;
      @(negedge clk);
      bus.rob_bht_en = 1'b0;
      en = 1'b1;
      #1;
      if (tk && m_bht[pc[7:2]] != 2'd3) m_bht[pc[7:2]]++;
      if (!tk && m_bht[pc[7:2]] != 2'd0) m_bht[pc[7:2]]--;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en = 1'b0;
      bus.ic_valid = 1'b0;
      bus.ic_ins = '0;
      bus.rob_flush = 1'b0;
      bus.rob_pc = '0;
      bus.rob_bht_en = 1'b0;
      bus.rob_bht_pc = '0;
      bus.rob_bht_taken = 1'b0;
      for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
      m_pc = 32'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
      checks++;
      if ({bus.ic_en, bus.ic_addr, bus.is_en, bus.is_ins, bus.is_bj, bus.is_pc, bus.is_pjt} !== '0) begin
         failures++;
         $display("FAIL reset_outputs ic_en=%b addr=%h is_en=%b ins=%h bj=%b pc=%h pjt=%h want all 0",
                  bus.ic_en, bus.ic_addr, bus.is_en, bus.is_ins, bus.is_bj, bus.is_pc, bus.is_pjt);
      end
      en = 1'b1;
      #1;
      checks++;
      if (bus.ic_en !== 1'b1) begin
         failures++;
         $display("FAIL reset_first_req got=%b want 1", bus.ic_en);
      end
   endtask

   task automatic test_basic();
      fetch_one(32'h00100093, 1);
   endtask

   task automatic test_jal();
      do_flush(32'h10);
      fetch_one(32'h0080006F, 1);
      checks++;
      if (bus.is_pjt !== 32'h18) begin
         failures++;
         $display("FAIL jal_target got=%h want=00000018", bus.is_pjt);
      end
      fetch_one(32'h00000013, 2);
   endtask

   task automatic test_branch();
      do_flush(32'h20);
      fetch_one(32'hFE000CE3, 1);
      do_flush(32'h20);
      fetch_one(32'h00000463, 1);
      checks++;
      if (bus.is_pjt !== 32'h24) begin
         failures++;
         $display("FAIL beq_fwd_target got=%h want=00000024", bus.is_pjt);
      end
   endtask

   task automatic test_stall();
      logic [97:0] snap;
      fetch_one(32'h00a00113, 1);
      snap = {bus.is_en, bus.is_ins, bus.is_bj, bus.is_pc, bus.is_pjt};
      en = 1'b0;
      repeat (5) begin
         @(negedge clk); #1;
         checks++;
         if (bus.ic_en !== 1'b0 || {bus.is_en, bus.is_ins, bus.is_bj, bus.is_pc, bus.is_pjt} !== snap) begin
            failures++;
            $display("FAIL stall_hold ic_en=%b is_en=%b pc=%h want ic_en=0 stable pc=%h",
                     bus.ic_en, bus.is_en, bus.is_pc, snap[63:32]);
         end
      end
      en = 1'b1;
      #1;
      checks++;
      if (bus.ic_en !== 1'b1) begin
         failures++;
         $display("FAIL stall_release ic_en=%b want 1", bus.ic_en);
      end
      fetch_one(32'h00000033, 2);
   endtask

   task automatic test_flush_wait();
      logic ok;
      wait_req(ok);
      @(negedge clk);
      bus.rob_flush = 1'b1;
      bus.rob_pc = 32'h100;
      #1;
      @(negedge clk);
      bus.rob_flush = 1'b0;
      #1;
      checks++;
      if (bus.ic_en !== 1'b0 || bus.is_en !== 1'b0) begin
         failures++;
         $display("FAIL drop_quiet ic_en=%b is_en=%b want 0 0", bus.ic_en, bus.is_en);
      end
      @(negedge clk);
      bus.ic_valid = 1'b1;
      bus.ic_ins = 32'h0080006F;
      @(negedge clk);
      bus.ic_valid = 1'b0;
      #1;
      checks++;
      if (bus.is_en !== 1'b0 || bus.ic_en !== 1'b1 || bus.ic_addr !== 32'h100) begin
         failures++;
         $display("FAIL drop_refetch is_en=%b ic_en=%b addr=%h want 0 1 00000100", bus.is_en, bus.ic_en, bus.ic_addr);
      end
      m_pc = 32'h100;
      fetch_one(32'h00100093, 1);
   endtask

   task automatic test_flush_resp();
      logic ok;
      wait_req(ok);
      @(negedge clk);
      bus.ic_valid = 1'b1;
      bus.ic_ins = 32'h00100093;
      bus.rob_flush = 1'b1;
      bus.rob_pc = 32'h200;
      @(negedge clk);
      bus.ic_valid = 1'b0;
      bus.rob_flush = 1'b0;
      #1;
      checks++;
      if (bus.is_en !== 1'b0 || bus.ic_en !== 1'b1 || bus.ic_addr !== 32'h200) begin
         failures++;
         $display("FAIL flush_with_resp is_en=%b ic_en=%b addr=%h want 0 1 00000200", bus.is_en, bus.ic_en, bus.ic_addr);
      end
      m_pc = 32'h200;
      fetch_one(32'h00000013, 1);
   endtask

   task automatic test_bht();
      do_flush(32'h40);
      bht_update(32'h40, 1'b1);
      bht_update(32'h40, 1'b1);
      fetch_one(32'h00000863, 1);
      do_flush(32'h40);
      bht_update(32'h40, 1'b0);
      bht_update(32'h40, 1'b0);
      fetch_one(32'h00000863, 1);
      checks++;
      if (bus.is_pjt !== 32'h44) begin
         failures++;
         $display("FAIL bht_not_taken got=%h want=00000044", bus.is_pjt);
      end
   endtask

   task automatic test_random();
      logic [6:0]  ops [5];
      logic [31:0] r;
      logic [31:0] p;
      ops = '{7'h6F, 7'h67, 7'h63, 7'h13, 7'h33};
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 9))
            0: begin
               p = $urandom_range(0, 255) << 2;
               do_flush(p);
            end
            1, 2: begin
               p = $urandom_range(0, 255) << 2;
               bht_update(p, 1'($urandom_range(0, 1)));
            end
            3: begin
               en = 1'b0;
               repeat ($urandom_range(1, 4)) @(negedge clk);
               en = 1'b1;
               #1;
            end
            default: ;
         endcase
         r = $urandom;
         fetch_one({r[31:7], ops[$urandom_range(0, 4)]}, $urandom_range(1, 3));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_jal();
      test_branch();
      test_stall();
      test_flush_wait();
      test_flush_resp();
      test_bht();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
